// File: rtl/adpll_node_controller_if.sv
// Port bundle for one ADPLL node controller: phase-detector inputs, loop gains,
// and the DCO/lock outputs. The controller takes the slave side.
interface adpll_node_controller_if #(
    parameter int NUM_CH   = 4,
    parameter int ERR_W    = 5,
    parameter int WEIGHT_W = 4,
    parameter int KP_W     = 8,
    parameter int KI_W     = 8,
    parameter int CC_W     = 5
);
    logic                         enable_i;
    logic                         gen_div_i;
    logic [NUM_CH*ERR_W-1:0]      error_i;
    logic [NUM_CH*WEIGHT_W-1:0]   weight_i;
    logic [KP_W-1:0]              kp_i;
    logic [KI_W-1:0]              ki_i;
    logic signed [ERR_W+1:0]      error_comb_o;
    logic signed [CC_W-1:0]       dco_cc_o;
    logic [CC_W-1:0]              freq_sel_o;
    logic                         update_o;
    logic                         locked_o;

    modport slave (
        input  enable_i, gen_div_i, error_i, weight_i, kp_i, ki_i,
        output error_comb_o, dco_cc_o, freq_sel_o, update_o, locked_o
    );
    modport master (
        output enable_i, gen_div_i, error_i, weight_i, kp_i, ki_i,
        input  error_comb_o, dco_cc_o, freq_sel_o, update_o, locked_o
    );
endinterface

// File: rtl/adpll_node_controller.sv
// ADPLL node control core: weighted N-channel error combiner, PI filter, DCO code map.
// Optional lock detect with proportional gear-shift enabled by ADPLL_LOCK_DETECT_EN.
module adpll_node_controller #(
    parameter int NUM_CH        = 4,
    parameter int ERR_W         = 5,
    parameter int WEIGHT_W      = 4,
    parameter int WEIGHT_SHIFT  = 1,
    parameter int KP_W          = 8,
    parameter int KI_W          = 8,
    parameter int FRAC_W        = 7,
    parameter int CC_W          = 5,
    parameter int BIAS          = 15,
    parameter int LOCK_TOL      = 1,
    parameter int LOCK_COUNT    = 8,
    parameter int UNLOCK_MISSES = 2
) (
    input  logic                   fpga_clk_i,
    input  logic                   reset_i,
    adpll_node_controller_if.slave bus
);
    localparam int PROD_W   = ERR_W + WEIGHT_W + 1;
    localparam int SUM_W    = PROD_W + $clog2(NUM_CH) + 1;
    localparam int COMB_W   = ERR_W + 2;
    localparam int ACC_W    = CC_W + FRAC_W + 2;
    localparam int GAIN_W   = ((KP_W > KI_W) ? KP_W : KI_W) + 1;
    localparam int WIDE_W   = (((COMB_W + GAIN_W) > ACC_W) ? (COMB_W + GAIN_W) : ACC_W) + 2;
    localparam int COMB_MAX = 2**(COMB_W-1) - 1;
    localparam int COMB_MIN = -(2**(COMB_W-1));
    localparam int ACC_MAX  = 2**(ACC_W-1) - 1;
    localparam int ACC_MIN  = -(2**(ACC_W-1));
    localparam int CC_MAX   = 2**(CC_W-1) - 1;
    localparam int CC_MIN   = -(2**(CC_W-1));
    localparam int FSEL_MAX = 2**CC_W - 1;

    // [0],[1] synchroniser, [2] edge-detect history
    logic [2:0]                      r_sync;
    logic [3:1]                      r_vld_pipe;
    logic                            w_strobe;
    logic [NUM_CH-1:0][PROD_W-1:0]   w_prod, r_prod;
    logic signed [SUM_W-1:0]         w_sum, w_sum_sh;
    logic signed [COMB_W-1:0]        w_comb_sat, r_comb;
    logic signed [ACC_W-1:0]         r_acc, w_acc_new;
    logic signed [CC_W-1:0]          r_dco, w_ctrl;
    logic [CC_W-1:0]                 r_freq, w_freq;
    logic [KP_W-1:0]                 w_kp_eff;
    logic signed [WIDE_W-1:0]        w_comb_x, w_kp_x, w_ki_x;
    logic signed [WIDE_W-1:0]        w_acc_sum, w_ctrl_sum, w_ctrl_sh, w_freq_x;

    assign w_strobe = r_sync[1] & ~r_sync[2] & bus.enable_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [PROD_W-1:0] w_e_x, w_w_x;
        assign w_e_x     = PROD_W'($signed(bus.error_i[c*ERR_W +: ERR_W]));
        assign w_w_x     = PROD_W'(bus.weight_i[c*WEIGHT_W +: WEIGHT_W]);
        assign w_prod[c] = w_e_x * w_w_x;
    end

    always_comb begin
        w_sum = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_sum = w_sum + SUM_W'($signed(r_prod[c]));
        w_sum_sh = w_sum >>> WEIGHT_SHIFT;
        if (w_sum_sh > COMB_MAX)
            w_comb_sat = COMB_W'(COMB_MAX);
        else if (w_sum_sh < COMB_MIN)
            w_comb_sat = COMB_W'(COMB_MIN);
        else
            w_comb_sat = w_sum_sh[COMB_W-1:0];
    end

    // PI filter: integrator saturates first, then proportional path is added on top
    always_comb begin
        w_comb_x  = WIDE_W'(r_comb);
        w_kp_x    = WIDE_W'(w_kp_eff);
        w_ki_x    = WIDE_W'(bus.ki_i);
        w_acc_sum = WIDE_W'(r_acc) + w_comb_x * w_ki_x;
        if (w_acc_sum > ACC_MAX)
            w_acc_new = ACC_W'(ACC_MAX);
        else if (w_acc_sum < ACC_MIN)
            w_acc_new = ACC_W'(ACC_MIN);
        else
            w_acc_new = w_acc_sum[ACC_W-1:0];
        w_ctrl_sum = w_comb_x * w_kp_x + WIDE_W'(w_acc_new);
        w_ctrl_sh  = w_ctrl_sum >>> FRAC_W;
        if (w_ctrl_sh > CC_MAX)
            w_ctrl = CC_W'(CC_MAX);
        else if (w_ctrl_sh < CC_MIN)
            w_ctrl = CC_W'(CC_MIN);
        else
            w_ctrl = w_ctrl_sh[CC_W-1:0];
        w_freq_x = WIDE_W'(BIAS) - WIDE_W'(w_ctrl);
        if (w_freq_x < 0)
            w_freq = '0;
        else if (w_freq_x > FSEL_MAX)
            w_freq = CC_W'(FSEL_MAX);
        else
            w_freq = w_freq_x[CC_W-1:0];
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync     <= '0;
            r_vld_pipe <= '0;
            r_prod     <= '0;
            r_comb     <= '0;
            r_acc      <= '0;
            r_dco      <= '0;
            r_freq     <= CC_W'(BIAS);
        end else begin
            r_sync     <= {r_sync[1:0], bus.gen_div_i};
            r_vld_pipe <= {r_vld_pipe[2:1], w_strobe};
            if (w_strobe)
                r_prod <= w_prod;
            if (r_vld_pipe[1])
                r_comb <= w_comb_sat;
            if (r_vld_pipe[2]) begin
                r_acc  <= w_acc_new;
                r_dco  <= w_ctrl;
                r_freq <= w_freq;
            end
        end
    end

    assign bus.error_comb_o = r_comb;
    assign bus.dco_cc_o     = r_dco;
    assign bus.freq_sel_o   = r_freq;
    assign bus.update_o     = r_vld_pipe[3];

`ifdef ADPLL_LOCK_DETECT_EN
    localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_MISSES + 1);

    typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} lock_state_e;

    lock_state_e       r_state, w_state_nxt;
    logic [HIT_W-1:0]  r_hit, w_hit_nxt;
    logic [MISS_W-1:0] r_miss, w_miss_nxt;
    logic              w_in_tol;

    assign w_in_tol = (r_comb <= LOCK_TOL) && (r_comb >= -LOCK_TOL);

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ACQUIRE;
            r_hit   <= '0;
            r_miss  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hit   <= w_hit_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    // Lock state only moves on an S3 update, so a disabled loop holds it
    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = r_hit;
        w_miss_nxt  = r_miss;
        if (r_vld_pipe[2]) begin
            case (r_state)
                ACQUIRE: begin
                    if (!w_in_tol)
                        w_hit_nxt = '0;
                    else if (int'(r_hit) + 1 >= LOCK_COUNT) begin
                        w_state_nxt = LOCKED;
                        w_hit_nxt   = '0;
                        w_miss_nxt  = '0;
                    end else
                        w_hit_nxt = r_hit + 1'b1;
                end
                LOCKED: begin
                    if (w_in_tol)
                        w_miss_nxt = '0;
                    else if (int'(r_miss) + 1 >= UNLOCK_MISSES) begin
                        w_state_nxt = ACQUIRE;
                        w_hit_nxt   = '0;
                        w_miss_nxt  = '0;
                    end else
                        w_miss_nxt = r_miss + 1'b1;
                end
                default: w_state_nxt = ACQUIRE;
            endcase
        end
    end

    assign w_kp_eff     = (r_state == LOCKED) ? (bus.kp_i >> 1) : bus.kp_i;
    assign bus.locked_o = (r_state == LOCKED);
`else
    logic w_unused_lock_cfg;
    assign w_unused_lock_cfg = (LOCK_TOL + LOCK_COUNT + UNLOCK_MISSES) != 0;
    assign w_kp_eff          = bus.kp_i;
    assign bus.locked_o      = 1'b0;
`endif
endmodule

// File: tb/tb_adpll_node_controller.sv
// Directed self-checking bench for adpll_node_controller (default parameters).
module tb_adpll_node_controller;
`ifdef ADPLL_LOCK_DETECT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    adpll_node_controller_if bus ();

    adpll_node_controller dut (
        .fpga_clk_i (clk),
        .reset_i    (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        bus.gen_div_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One gen_div rising edge; reports first update latency in clocks and the pulse count
    task automatic do_edge(output int lat, output int n_upd, output logic lk);
        lat   = -1;
        n_upd = 0;
        lk    = 1'bx;
        bus.gen_div_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 4) bus.gen_div_i = 1'b0;
            if (bus.update_o === 1'b1) begin
                n_upd++;
                if (lat < 0) begin
                    lat = k;
                    lk  = bus.locked_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        int n_upd;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (32'(bus.error_comb_o) !== 0) begin n_fail++; $display("FAIL rst_comb: got %0d want 0", $signed(bus.error_comb_o)); end
        n_checks++; if (32'(bus.dco_cc_o) !== 0) begin n_fail++; $display("FAIL rst_dco: got %0d want 0", $signed(bus.dco_cc_o)); end
        n_checks++; if (bus.freq_sel_o !== 5'd15) begin n_fail++; $display("FAIL rst_freq: got %0d want 15", bus.freq_sel_o); end
        n_checks++; if (bus.update_o !== 1'b0) begin n_fail++; $display("FAIL rst_update: got %b want 0", bus.update_o); end
        n_checks++; if (bus.locked_o !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b want 0", bus.locked_o); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // start a sample, abort it with reset while it is in the pipeline
        bus.error_i  = 20'h00004;
        bus.weight_i = 16'h0002;
        bus.kp_i     = 8'd128;
        bus.gen_div_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.gen_div_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_upd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.update_o !== 1'b0) n_upd++;
        end
        n_checks++; if (n_upd !== 0) begin n_fail++; $display("FAIL midrst_update: got %0d pulses want 0", n_upd); end
        n_checks++; if (bus.freq_sel_o !== 5'd15) begin n_fail++; $display("FAIL midrst_freq: got %0d want 15", bus.freq_sel_o); end
        n_checks++; if (32'(bus.dco_cc_o) !== 0) begin n_fail++; $display("FAIL midrst_dco: got %0d want 0", $signed(bus.dco_cc_o)); end
    endtask

    task automatic test_proportional();
        int lat, n_upd; logic lk;
        apply_reset();
        bus.error_i  = 20'h00004;
        bus.weight_i = 16'h0002;
        bus.kp_i     = 8'd128;
        bus.ki_i     = 8'd0;
        do_edge(lat, n_upd, lk);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL prop_latency: got %0d want 5", lat); end
        n_checks++; if (n_upd !== 1) begin n_fail++; $display("FAIL prop_pulses: got %0d want 1", n_upd); end
        n_checks++; if (32'(bus.error_comb_o) !== 4) begin n_fail++; $display("FAIL prop_comb: got %0d want 4", $signed(bus.error_comb_o)); end
        n_checks++; if (32'(bus.dco_cc_o) !== 4) begin n_fail++; $display("FAIL prop_dco: got %0d want 4", $signed(bus.dco_cc_o)); end
        n_checks++; if (bus.freq_sel_o !== 5'd11) begin n_fail++; $display("FAIL prop_freq: got %0d want 11", bus.freq_sel_o); end
    endtask

    task automatic test_integral();
        int lat, n_upd; logic lk;
        int exp_dco [4]  = '{0, 1, 1, 2};
        int exp_freq [4] = '{15, 14, 14, 13};
        apply_reset();
        bus.error_i  = 20'h00004;
        bus.weight_i = 16'h0002;
        bus.kp_i     = 8'd0;
        bus.ki_i     = 8'd16;
        for (int i = 0; i < 4; i++) begin
            do_edge(lat, n_upd, lk);
            n_checks++; if (32'(bus.dco_cc_o) !== exp_dco[i]) begin n_fail++; $display("FAIL int_dco[%0d]: got %0d want %0d", i, $signed(bus.dco_cc_o), exp_dco[i]); end
            n_checks++; if (32'(bus.freq_sel_o) !== exp_freq[i]) begin n_fail++; $display("FAIL int_freq[%0d]: got %0d want %0d", i, bus.freq_sel_o, exp_freq[i]); end
        end
    endtask

    task automatic test_saturation();
        int lat, n_upd; logic lk;
        apply_reset();
        bus.error_i  = 20'h7BDEF;   // all channels +15
        bus.weight_i = 16'hFFFF;
        bus.kp_i     = 8'd255;
        bus.ki_i     = 8'd0;
        do_edge(lat, n_upd, lk);
        n_checks++; if (32'(bus.error_comb_o) !== 63) begin n_fail++; $display("FAIL satp_comb: got %0d want 63", $signed(bus.error_comb_o)); end
        n_checks++; if (32'(bus.dco_cc_o) !== 15) begin n_fail++; $display("FAIL satp_dco: got %0d want 15", $signed(bus.dco_cc_o)); end
        n_checks++; if (bus.freq_sel_o !== 5'd0) begin n_fail++; $display("FAIL satp_freq: got %0d want 0", bus.freq_sel_o); end
        bus.error_i = 20'h84210;    // all channels -16
        do_edge(lat, n_upd, lk);
        n_checks++; if (32'(bus.error_comb_o) !== -64) begin n_fail++; $display("FAIL satn_comb: got %0d want -64", $signed(bus.error_comb_o)); end
        n_checks++; if (32'(bus.dco_cc_o) !== -16) begin n_fail++; $display("FAIL satn_dco: got %0d want -16", $signed(bus.dco_cc_o)); end
        n_checks++; if (bus.freq_sel_o !== 5'd31) begin n_fail++; $display("FAIL satn_freq: got %0d want 31", bus.freq_sel_o); end
    endtask

    task automatic test_enable();
        int lat, n_upd, tot; logic lk;
        apply_reset();
        bus.error_i  = 20'h00004;
        bus.weight_i = 16'h0002;
        bus.kp_i     = 8'd0;
        bus.ki_i     = 8'd16;
        do_edge(lat, n_upd, lk);
        do_edge(lat, n_upd, lk);   // acc = 128
        bus.enable_i = 1'b0;
        bus.error_i  = 20'h00018;  // ch0 -8: would pull acc down if not ignored
        tot = 0;
        for (int i = 0; i < 2; i++) begin
            do_edge(lat, n_upd, lk);
            tot += n_upd;
        end
        n_checks++; if (tot !== 0) begin n_fail++; $display("FAIL dis_update: got %0d pulses want 0", tot); end
        n_checks++; if (32'(bus.error_comb_o) !== 4) begin n_fail++; $display("FAIL dis_comb: got %0d want 4", $signed(bus.error_comb_o)); end
        n_checks++; if (32'(bus.dco_cc_o) !== 1) begin n_fail++; $display("FAIL dis_dco: got %0d want 1", $signed(bus.dco_cc_o)); end
        n_checks++; if (bus.freq_sel_o !== 5'd14) begin n_fail++; $display("FAIL dis_freq: got %0d want 14", bus.freq_sel_o); end
        bus.enable_i = 1'b1;
        bus.error_i  = 20'h00004;
        do_edge(lat, n_upd, lk);   // acc = 192
        n_checks++; if (32'(bus.dco_cc_o) !== 1) begin n_fail++; $display("FAIL reen1_dco: got %0d want 1", $signed(bus.dco_cc_o)); end
        do_edge(lat, n_upd, lk);   // acc = 256
        n_checks++; if (32'(bus.dco_cc_o) !== 2) begin n_fail++; $display("FAIL reen2_dco: got %0d want 2", $signed(bus.dco_cc_o)); end
        n_checks++; if (bus.freq_sel_o !== 5'd13) begin n_fail++; $display("FAIL reen2_freq: got %0d want 13", bus.freq_sel_o); end
    endtask

    task automatic test_back_to_back();
        int n_upd, lat, n1; logic lk;
        apply_reset();
        bus.error_i  = 20'h00004;
        bus.weight_i = 16'h0002;
        bus.kp_i     = 8'd0;
        bus.ki_i     = 8'd16;
        // gen_div toggling every clock gives a detected edge every second cycle
        n_upd = 0;
        for (int k = 0; k < 18; k++) begin
            bus.gen_div_i = (k < 6) ? ~k[0] : 1'b0;
            @(negedge clk);
            if (bus.update_o === 1'b1) n_upd++;
        end
        n_checks++; if (n_upd !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 3", n_upd); end
        n_checks++; if (32'(bus.dco_cc_o) !== 1) begin n_fail++; $display("FAIL b2b_dco: got %0d want 1", $signed(bus.dco_cc_o)); end
        do_edge(lat, n1, lk);      // acc = 256
        n_checks++; if (32'(bus.dco_cc_o) !== 2) begin n_fail++; $display("FAIL b2b_next_dco: got %0d want 2", $signed(bus.dco_cc_o)); end
    endtask

    task automatic test_lock();
        int lat, n_upd; logic lk;
        apply_reset();
        bus.error_i  = 20'h00000;
        bus.weight_i = 16'h0000;
        bus.kp_i     = 8'd128;
        bus.ki_i     = 8'd0;
        for (int i = 0; i < 8; i++) begin
            do_edge(lat, n_upd, lk);
            if (i == 6) begin
                n_checks++; if (lk !== 1'b0) begin n_fail++; $display("FAIL lock_7th: got %b want 0", lk); end
            end
        end
        n_checks++; if (lk !== LOCK_EN) begin n_fail++; $display("FAIL lock_8th: got %b want %b", lk, LOCK_EN); end
        bus.error_i  = 20'h00004;
        bus.weight_i = 16'h0002;
        do_edge(lat, n_upd, lk);   // first miss, gear-shifted kp while locked
        n_checks++; if (lk !== LOCK_EN) begin n_fail++; $display("FAIL miss1_locked: got %b want %b", lk, LOCK_EN); end
        n_checks++; if (32'(bus.dco_cc_o) !== (LOCK_EN ? 2 : 4)) begin n_fail++; $display("FAIL miss1_dco: got %0d want %0d", $signed(bus.dco_cc_o), LOCK_EN ? 2 : 4); end
        do_edge(lat, n_upd, lk);   // second miss drops lock
        n_checks++; if (lk !== 1'b0) begin n_fail++; $display("FAIL miss2_locked: got %b want 0", lk); end
        n_checks++; if (32'(bus.dco_cc_o) !== (LOCK_EN ? 2 : 4)) begin n_fail++; $display("FAIL miss2_dco: got %0d want %0d", $signed(bus.dco_cc_o), LOCK_EN ? 2 : 4); end
        do_edge(lat, n_upd, lk);   // back in ACQUIRE, full kp
        n_checks++; if (32'(bus.dco_cc_o) !== 4) begin n_fail++; $display("FAIL acq_dco: got %0d want 4", $signed(bus.dco_cc_o)); end
        n_checks++; if (bus.locked_o !== 1'b0) begin n_fail++; $display("FAIL acq_locked: got %b want 0", bus.locked_o); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.enable_i  = 1'b1;
        bus.gen_div_i = 1'b0;
        bus.error_i   = '0;
        bus.weight_i  = '0;
        bus.kp_i      = '0;
        bus.ki_i      = '0;
        test_reset();
        test_proportional();
        test_integral();
        test_saturation();
        test_enable();
        test_back_to_back();
        test_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
